// File: rtl/rx_depacketizer.sv
// BPSK packet depacketizer: training skip, length header, payload bytes.
// Optional CRC-8 trailer check enabled by defining RX_DEPKT_CRC_EN.
module rx_depacketizer #(
  parameter int TRN_SKIP  = 16,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_enable,
  input  logic                 BPSK,
  input  logic                 PD_flag,
  input  logic                 BD_flag,
  input  logic                 BD_sgn,
  output logic                 disassert_BD,
  output logic [7:0]           data_out,
  output logic                 data_vld,
  output logic [LEN_WIDTH-1:0] len_out,
  output logic                 pkt_start,
  output logic                 pkt_done,
  output logic                 pkt_err,
  output logic                 crc_ok
);

  typedef enum logic [2:0] {
    IDLE,
    TRN,
    HDR,
    PAY,
`ifdef RX_DEPKT_CRC_EN
    CRC,
`endif
    DONE
  } state_t;

`ifdef RX_DEPKT_CRC_EN
  localparam state_t POST = CRC;
`else
  localparam state_t POST = DONE;
`endif

  localparam int CMAX =
    (TRN_SKIP > LEN_WIDTH) ? TRN_SKIP :
    ((LEN_WIDTH > 8) ? LEN_WIDTH : 8);
  localparam int CW = $clog2(CMAX + 1);

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [LEN_WIDTH-1:0] byte_cnt_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [6:0]           sh_q;
  logic                 armed_q;
  logic [7:0]           data_q;
  logic                 vld_q;
  logic                 start_q;
  logic                 done_q;
  logic                 err_q;
  logic                 dis_q;

  logic                 cbit;
  logic                 in_pkt;
  logic                 abort;
  logic [LEN_WIDTH-1:0] len_d;
  logic [7:0]           sh_d;

  assign cbit  = ~(BPSK ^ BD_sgn);
  assign len_d = {len_q[LEN_WIDTH-2:0], cbit};
  assign sh_d  = {sh_q, cbit};

  always_comb begin
    in_pkt = 1'b0;
    unique case (state_q)
      TRN, HDR, PAY: in_pkt = 1'b1;
`ifdef RX_DEPKT_CRC_EN
      CRC:           in_pkt = 1'b1;
`endif
      default:       in_pkt = 1'b0;
    endcase
  end

  assign abort = clk_enable & ~PD_flag & in_pkt;

`ifdef RX_DEPKT_CRC_EN
  logic [7:0] crc_calc_q;
  logic [7:0] crc_calc_d;
  logic [6:0] crc_rx_q;
  logic [7:0] crc_rx_d;
  logic       crc_ok_q;

  // Bit-serial CRC-8, poly 0x07, MSB first.
  assign crc_calc_d = {crc_calc_q[6:0], 1'b0}
                    ^ ((crc_calc_q[7] ^ cbit) ? 8'h07 : 8'h00);
  assign crc_rx_d   = {crc_rx_q, cbit};
  assign crc_ok     = crc_ok_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_calc_q <= '0;
      crc_rx_q   <= '0;
      crc_ok_q   <= 1'b0;
    end else if (clk_enable && !abort) begin
      unique case (state_q)
        IDLE: crc_calc_q <= '0;
        HDR, PAY: crc_calc_q <= crc_calc_d;
        CRC: begin
          crc_rx_q <= crc_rx_d[6:0];
          if (cnt_q == CW'(7))
            crc_ok_q <= (crc_rx_d == crc_calc_q);
        end
        default: ;
      endcase
    end
  end
`else
  assign crc_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      sh_q       <= '0;
      armed_q    <= 1'b1;
      data_q     <= '0;
      vld_q      <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      dis_q      <= 1'b0;
    end else begin
      vld_q   <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dis_q   <= 1'b0;
      if (abort) begin
        err_q   <= 1'b1;
        dis_q   <= 1'b1;
        cnt_q   <= '0;
        armed_q <= 1'b0;
        state_q <= IDLE;
      end else if (clk_enable) begin
        unique case (state_q)
          IDLE: begin
            // Re-arm only after the boundary flag has dropped.
            if (!BD_flag)
              armed_q <= 1'b1;
            if (armed_q && BD_flag && PD_flag) begin
              armed_q    <= 1'b0;
              cnt_q      <= '0;
              byte_cnt_q <= '0;
              state_q    <= (TRN_SKIP == 0) ? HDR : TRN;
            end
          end
          TRN: begin
            if (int'(cnt_q) == TRN_SKIP - 1) begin
              cnt_q   <= '0;
              state_q <= HDR;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          HDR: begin
            len_q <= len_d;
            if (int'(cnt_q) == LEN_WIDTH - 1) begin
              cnt_q   <= '0;
              start_q <= 1'b1;
              state_q <= (len_d != '0) ? PAY : POST;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          PAY: begin
            sh_q <= sh_d[6:0];
            if (cnt_q == CW'(7)) begin
              cnt_q      <= '0;
              data_q     <= sh_d;
              vld_q      <= 1'b1;
              byte_cnt_q <= byte_cnt_q + 1'b1;
              if (byte_cnt_q == len_q - 1'b1)
                state_q <= POST;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
`ifdef RX_DEPKT_CRC_EN
          CRC: begin
            if (cnt_q == CW'(7)) begin
              cnt_q   <= '0;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
`endif
          DONE: begin
            done_q  <= 1'b1;
            dis_q   <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_out     = data_q;
  assign data_vld     = vld_q;
  assign len_out      = len_q;
  assign pkt_start    = start_q;
  assign pkt_done     = done_q;
  assign pkt_err      = err_q;
  assign disassert_BD = dis_q;

endmodule
